resync_tx: RTL

Serial ReSync command transmitter: the sending end of the fast-command line decoded by the SyncUnit `serial_in`. It accepts 4-bit command codes through a valid/ready port, buffers them, Hamming-encodes each into an 8-bit codeword, and shifts it out MSB-first framed by a start bit and guard zeros. It also inserts periodic BC0 commands at orbit boundaries. It is used in the off-detector emulator and as the synthesizable stimulus source for system benches driving `ReSync`.

---
 rtl/resync_pkg.sv | 37 +++
 rtl/resync_cmd_fifo.sv | 48 ++++
 rtl/resync_tx.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/resync_pkg.sv
// ReSync transmitter shared definitions.
// Command codes, frame constants and the Hamming(8,4) encoder.
package resync_pkg;

  localparam logic [3:0] CMD_DTU_RST   = 4'h0;
  localparam logic [3:0] CMD_I2C_RST   = 4'h1;
  localparam logic [3:0] CMD_ADCH_RST  = 4'h2;
  localparam logic [3:0] CMD_ADCL_RST  = 4'h3;
  localparam logic [3:0] CMD_ADCH_CAL  = 4'h4;
  localparam logic [3:0] CMD_ADCL_CAL  = 4'h5;
  localparam logic [3:0] CMD_BC0       = 4'h6;
  localparam logic [3:0] CMD_CATIA_TP  = 4'h7;
  localparam logic [3:0] CMD_PLL_START = 4'h8;
  localparam logic [3:0] CMD_SYNC_MODE = 4'h9;
  localparam logic [3:0] CMD_NORM_MODE = 4'hA;
  localparam logic [3:0] CMD_FLUSH     = 4'hB;

  localparam int FRAME_DATA_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_GUARD
  } txState_e;

  function automatic logic [7:0] resync_hamming84(input logic [3:0] d);
    logic [7:0] cw;
    cw[7:4] = d;
    cw[3]   = d[0] ^ d[1] ^ d[3];
    cw[2]   = d[0] ^ d[2] ^ d[3];
    cw[1]   = d[1] ^ d[2] ^ d[3];
    cw[0]   = ^cw[7:1];
    return cw;
  endfunction

endpackage

// File: rtl/resync_cmd_fifo.sv
// Command FIFO for the ReSync transmitter.
// DEPTH x 4-bit entries, extra pointer bit distinguishes full/empty.
module resync_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       wrEn,
  input  logic [3:0] wrData,
  input  logic       rdEn,
  output logic [3:0] rdData,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [3:0]  mem [DEPTH];
  logic [AW:0] wrPtr;
  logic [AW:0] rdPtr;
  logic        doWr;
  logic        doRd;

  assign doWr   = wrEn && !full;
  assign doRd   = rdEn && !empty;
  assign empty  = wrPtr == rdPtr;
  assign full   = (wrPtr[AW] != rdPtr[AW]) &&
                  (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign rdData = mem[rdPtr[AW-1:0]];

  // Pointer advance on accepted write / pop.
  always_ff @(posedge clock) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doWr) wrPtr <= wrPtr + PTR_ONE;
      if (doRd) rdPtr <= rdPtr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clock) begin
    if (doWr) mem[wrPtr[AW-1:0]] <= wrData;
  end

endmodule

// File: rtl/resync_tx.sv
// Serial ReSync command transmitter.
// Frames: start bit, Hamming codeword MSB-first, GUARD zeros; BC0 per orbit.
module resync_tx
  import resync_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int GUARD     = 2,
  parameter int ORBIT_LEN = 3564
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_code,
  output logic       cmd_ready,
  input  logic       bc0_en,
  output logic       serial_out,
  output logic       busy,
  output logic       bc0_sent,
  output logic       bc0_overrun
);

  localparam int CNT_MAX =
    (GUARD > FRAME_DATA_BITS) ? GUARD : FRAME_DATA_BITS;
  localparam int CW = $clog2(CNT_MAX);
  localparam int OW = $clog2(ORBIT_LEN);

  localparam logic [CW-1:0] DATA_LAST  = CW'(FRAME_DATA_BITS - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
  localparam logic [CW-1:0] CNT_ONE    = 1;
  localparam logic [OW-1:0] ORBIT_LAST = OW'(ORBIT_LEN - 1);
  localparam logic [OW-1:0] ORBIT_ONE  = 1;

  txState_e      state;
  txState_e      stateNext;
  logic [CW-1:0] bitCnt;
  logic [CW-1:0] bitCntNext;
  logic [7:0]    shiftReg;
  logic          frameIsBc0;
  logic          load;
  logic          lineBit;
  logic          lineBusyQ;
  logic          readyEn;

  logic [OW-1:0] orbitCnt;
  logic          orbitWrap;
  logic          bc0Pend;
  logic          takeBc0;

  logic          workPending;
  logic          fifoWr;
  logic          fifoPop;
  logic [3:0]    fifoHead;
  logic          fifoFull;
  logic          fifoEmpty;

  assign workPending = bc0Pend || !fifoEmpty;
  assign takeBc0     = load && bc0Pend;
  assign fifoPop     = load && !bc0Pend;
  assign cmd_ready   = readyEn && !fifoFull;
  assign fifoWr      = cmd_valid && cmd_ready;
  assign orbitWrap   = orbitCnt == ORBIT_LAST;
  assign busy        = !fifoEmpty || (state != ST_IDLE) || lineBusyQ;

  resync_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock  (clock),
    .rst    (rst),
    .wrEn   (fifoWr),
    .wrData (cmd_code),
    .rdEn   (fifoPop),
    .rdData (fifoHead),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  // Frame sequencing; a new frame is chosen only from IDLE or end of GUARD.
  always_comb begin
    stateNext  = state;
    bitCntNext = bitCnt;
    load       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (workPending) begin
          stateNext = ST_START;
          load      = 1'b1;
        end
      end
      ST_START: begin
        stateNext  = ST_DATA;
        bitCntNext = '0;
      end
      ST_DATA: begin
        if (bitCnt == DATA_LAST) begin
          stateNext  = ST_GUARD;
          bitCntNext = '0;
        end else begin
          bitCntNext = bitCnt + CNT_ONE;
        end
      end
      ST_GUARD: begin
        if (bitCnt == GUARD_LAST) begin
          bitCntNext = '0;
          if (workPending) begin
            stateNext = ST_START;
            load      = 1'b1;
          end else begin
            stateNext = ST_IDLE;
          end
        end else begin
          bitCntNext = bitCnt + CNT_ONE;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // Bit currently presented by the frame state; registered onto the line.
  always_comb begin
    lineBit = 1'b0;
    unique case (1'b1)
      state == ST_START: lineBit = 1'b1;
      state == ST_DATA:  lineBit = shiftReg[7];
      default:           lineBit = 1'b0;
    endcase
  end

  // FSM state, bit counter and codeword shift register.
  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= ST_IDLE;
      bitCnt     <= '0;
      shiftReg   <= '0;
      frameIsBc0 <= 1'b0;
    end else begin
      state  <= stateNext;
      bitCnt <= bitCntNext;
      if (load) begin
        shiftReg   <= resync_hamming84(bc0Pend ? CMD_BC0 : fifoHead);
        frameIsBc0 <= bc0Pend;
      end else if (state == ST_DATA) begin
        shiftReg <= {shiftReg[6:0], 1'b0};
      end
    end
  end

  // Registered line outputs, one cycle behind the frame state.
  always_ff @(posedge clock) begin
    if (rst) begin
      serial_out <= 1'b0;
      bc0_sent   <= 1'b0;
      lineBusyQ  <= 1'b0;
      readyEn    <= 1'b0;
    end else begin
      serial_out <= lineBit;
      bc0_sent   <= (state == ST_START) && frameIsBc0;
      lineBusyQ  <= state != ST_IDLE;
      readyEn    <= 1'b1;
    end
  end

  // Orbit counter and BC0 pending flag; a wrap always wins over service.
  always_ff @(posedge clock) begin
    if (rst || !bc0_en) begin
      orbitCnt    <= '0;
      bc0Pend     <= 1'b0;
      bc0_overrun <= 1'b0;
    end else begin
      bc0_overrun <= orbitWrap && bc0Pend;
      orbitCnt    <= orbitWrap ? '0 : orbitCnt + ORBIT_ONE;
      if (orbitWrap) bc0Pend <= 1'b1;
      else if (takeBc0) bc0Pend <= 1'b0;
    end
  end

endmodule
